sc_stream_counter: RTL and testbench

Windowed stochastic-to-binary converter that sits directly downstream of the mux-based stochastic adder. It counts the ones in the adder's single-bit output stream over a fixed window of 2^WIDTH clock cycles. It then presents the count as a binary result through a valid/ack handshake. It closes the loop for accuracy benches and for feeding binary stages after a stochastic datapath.

---
 rtl/sc_stream_counter.sv | 119 +++++++++++
 tb/tb_sc_stream_counter.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/sc_stream_counter.sv
// Windowed stochastic-to-binary converter: counts ones of in_bit over 2^WIDTH cycles.
// Optional feature macro COUNT_SCALE_EN: result = count << LOGSCALE (undoes the adder's 1/2^LOGSCALE scaling).
module sc_stream_counter #(
  parameter int WIDTH    = 8,
  parameter int LOGSCALE = 3
) (
  input  logic clk,
  input  logic rst_n,
  input  logic in_bit,
  input  logic start,
  input  logic clr,
  input  logic ack,
  output logic busy,
  output logic valid,
`ifdef COUNT_SCALE_EN
  output logic [WIDTH+LOGSCALE:0] result
`else
  output logic [WIDTH:0] result
`endif
);

`ifdef COUNT_SCALE_EN
  localparam int RW = WIDTH + 1 + LOGSCALE;
`else
  localparam int RW = WIDTH + 1;
`endif

  localparam logic [WIDTH:0] LAST = {1'b0, {WIDTH{1'b1}}};
  localparam logic [WIDTH:0] ONE  = {{WIDTH{1'b0}}, 1'b1};
  localparam logic [WIDTH:0] ZERO = '0;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t          state_reg, state_next;
  logic [WIDTH:0]  cyc_reg, cyc_next;
  logic [WIDTH:0]  acc_reg, acc_next;
  logic [RW-1:0]   result_reg, result_next;
  logic            busy_reg, busy_next;
  logic            valid_reg, valid_next;
  logic [WIDTH:0]  sum;
  logic [RW-1:0]   scaled;

  // acc never exceeds 2^WIDTH, so WIDTH+1 bits hold the final sample too
  assign sum = acc_reg + (in_bit ? ONE : ZERO);

`ifdef COUNT_SCALE_EN
  assign scaled = {sum, {LOGSCALE{1'b0}}};
`else
  assign scaled = sum;
`endif

  always_comb begin
    state_next  = state_reg;
    cyc_next    = cyc_reg;
    acc_next    = acc_reg;
    result_next = result_reg;
    if (clr) begin
      state_next = IDLE;
      cyc_next   = ZERO;
      acc_next   = ZERO;
    end else begin
      case (state_reg)
        IDLE: begin
          if (start) begin
            state_next = RUN;
            cyc_next   = ZERO;
            acc_next   = ZERO;
          end
        end
        RUN: begin
          acc_next = sum;
          cyc_next = cyc_reg + ONE;
          if (cyc_reg == LAST) begin
            result_next = scaled;
            state_next  = DONE;
          end
        end
        DONE: begin
          // ack together with start chains straight into the next window
          if (ack) begin
            if (start) begin
              state_next = RUN;
              cyc_next   = ZERO;
              acc_next   = ZERO;
            end else begin
              state_next = IDLE;
            end
          end
        end
        default: state_next = IDLE;
      endcase
    end
    busy_next  = (state_next == RUN);
    valid_next = (state_next == DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg  <= IDLE;
      cyc_reg    <= '0;
      acc_reg    <= '0;
      result_reg <= '0;
      busy_reg   <= 1'b0;
      valid_reg  <= 1'b0;
    end else begin
      state_reg  <= state_next;
      cyc_reg    <= cyc_next;
      acc_reg    <= acc_next;
      result_reg <= result_next;
      busy_reg   <= busy_next;
      valid_reg  <= valid_next;
    end
  end

  assign busy   = busy_reg;
  assign valid  = valid_reg;
  assign result = result_reg;

endmodule

// File: tb/tb_sc_stream_counter.sv
// Self-checking bench for sc_stream_counter (WIDTH=8) with a count-the-ones reference model.
module tb_sc_stream_counter;
`ifdef COUNT_SCALE_EN
  localparam int SC = 3;
`else
  localparam int SC = 0;
`endif
  localparam int N  = 256;
  localparam int RW = 9 + SC;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic in_bit = 1'b0;
  logic start = 1'b0;
  logic clr = 1'b0;
  logic ack = 1'b0;
  logic busy;
  logic valid;
  logic [RW-1:0] result;

  int errors = 0;
  int checks = 0;

  sc_stream_counter #(.WIDTH(8), .LOGSCALE(3)) dut (
    .clk(clk), .rst_n(rst_n), .in_bit(in_bit), .start(start), .clr(clr),
    .ack(ack), .busy(busy), .valid(valid), .result(result)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference: expected result is simply the number of ones sampled, scaled.
  function automatic logic [RW-1:0] model(input int ones);
    logic [RW-1:0] r;
    r = RW'(ones * (1 << SC));
    return r;
  endfunction

  // Feeds n samples; reports ones fed and any early valid / dropped busy before the last sample.
  task automatic run_samples(input int n, input int mode, output int ones, output int glitches);
    int dens;
    logic b;
    ones = 0;
    glitches = 0;
    dens = $urandom_range(0, 100);
    for (int i = 0; i < n; i++) begin
      case (mode)
        0: b = 1'b0;
        1: b = 1'b1;
        2: b = (i % 2 == 0);
        default: b = ($urandom_range(0, 99) < dens);
      endcase
      in_bit = b;
      ones += int'(b);
      tick();
      if (i < n - 1 && (valid || !busy)) glitches++;
    end
    in_bit = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    tick();
    checks++;
    if ({busy, valid} !== 2'b00 || result !== '0) begin
      errors++;
      $display("FAIL reset: busy=%0b valid=%0b result=%0d, want 0 0 0", busy, valid, result);
    end
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    checks++;
    if ({busy, valid} !== 2'b00) begin
      errors++;
      $display("FAIL reset_release_idle: busy=%0b valid=%0b, want 0 0", busy, valid);
    end
    $display("reset: busy=%0b valid=%0b result=%0d", busy, valid, result);
  endtask

  task automatic test_window(input int mode, input string name);
    int ones, gl;
    logic [RW-1:0] exp;
    start = 1'b1;
    tick();
    start = 1'b0;
    checks++;
    if (busy !== 1'b1 || valid !== 1'b0) begin
      errors++;
      $display("FAIL %s_start: busy=%0b valid=%0b, want 1 0", name, busy, valid);
    end
    run_samples(N, mode, ones, gl);
    exp = model(ones);
    checks++;
    if (gl != 0) begin
      errors++;
      $display("FAIL %s_latency: %0d early valid/busy-drop cycles, want 0", name, gl);
    end
    checks++;
    if (valid !== 1'b1 || busy !== 1'b0 || result !== exp) begin
      errors++;
      $display("FAIL %s_result: valid=%0b busy=%0b result=%0d, want 1 0 %0d", name, valid, busy, result, exp);
    end
    ack = 1'b1;
    tick();
    ack = 1'b0;
    checks++;
    if (valid !== 1'b0 || busy !== 1'b0 || result !== exp) begin
      errors++;
      $display("FAIL %s_ack: valid=%0b busy=%0b result=%0d, want 0 0 %0d", name, valid, busy, result, exp);
    end
    $display("window %s: ones=%0d result=%0d expected=%0d", name, ones, result, exp);
  endtask

  task automatic test_ignored();
    int ones;
    logic [RW-1:0] exp;
    ones = 0;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < N; i++) begin
      in_bit = $urandom_range(0, 1) == 1;
      start = (i == 50 || i == 51 || i == 200);
      ones += int'(in_bit);
      tick();
    end
    start = 1'b0;
    exp = model(ones);
    checks++;
    if (valid !== 1'b1 || result !== exp) begin
      errors++;
      $display("FAIL ignored_run_start: valid=%0b result=%0d, want 1 %0d", valid, result, exp);
    end
    start = 1'b1;
    repeat (3) tick();
    start = 1'b0;
    checks++;
    if (valid !== 1'b1 || busy !== 1'b0 || result !== exp) begin
      errors++;
      $display("FAIL ignored_done_start: valid=%0b busy=%0b result=%0d, want 1 0 %0d", valid, busy, result, exp);
    end
    ack = 1'b1;
    tick();
    tick();
    ack = 1'b0;
    checks++;
    if (valid !== 1'b0 || busy !== 1'b0 || result !== exp) begin
      errors++;
      $display("FAIL ignored_idle_ack: valid=%0b busy=%0b result=%0d, want 0 0 %0d", valid, busy, result, exp);
    end
    $display("ignored starts: result=%0d expected=%0d", result, exp);
  endtask

  task automatic test_back_to_back();
    int ones, gl;
    start = 1'b1;
    tick();
    start = 1'b0;
    run_samples(N, 2, ones, gl);
    checks++;
    if (valid !== 1'b1 || result !== model(ones)) begin
      errors++;
      $display("FAIL b2b_first: valid=%0b result=%0d, want 1 %0d", valid, result, model(ones));
    end
    ack = 1'b1;
    start = 1'b1;
    tick();
    ack = 1'b0;
    start = 1'b0;
    checks++;
    if (valid !== 1'b0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL b2b_handover: valid=%0b busy=%0b, want 0 1", valid, busy);
    end
    run_samples(N, 1, ones, gl);
    checks++;
    if (gl != 0 || valid !== 1'b1 || result !== model(256)) begin
      errors++;
      $display("FAIL b2b_second: glitches=%0d valid=%0b result=%0d, want 0 1 %0d", gl, valid, result, model(256));
    end
    ack = 1'b1;
    tick();
    ack = 1'b0;
    $display("back-to-back: second result=%0d expected=%0d", result, model(256));
  endtask

  task automatic test_reset_midrun();
    int ones, gl;
    start = 1'b1;
    tick();
    start = 1'b0;
    run_samples(100, 3, ones, gl);
    rst_n = 1'b0;
    #1;
    checks++;
    if ({busy, valid} !== 2'b00 || result !== '0) begin
      errors++;
      $display("FAIL reset_midrun: busy=%0b valid=%0b result=%0d, want 0 0 0", busy, valid, result);
    end
    @(negedge clk);
    rst_n = 1'b1;
    $display("reset mid-run: busy=%0b valid=%0b result=%0d", busy, valid, result);
    test_window(1, "after_reset");
  endtask

  task automatic test_clr();
    int ones, gl;
    logic [RW-1:0] kept;
    test_window(2, "before_clr");
    kept = model(128);
    start = 1'b1;
    tick();
    start = 1'b0;
    run_samples(100, 3, ones, gl);
    clr = 1'b1;
    start = 1'b1;
    tick();
    clr = 1'b0;
    start = 1'b0;
    checks++;
    if (busy !== 1'b0 || valid !== 1'b0 || result !== kept) begin
      errors++;
      $display("FAIL clr_midrun: busy=%0b valid=%0b result=%0d, want 0 0 %0d", busy, valid, result, kept);
    end
    test_window(1, "after_clr");
    start = 1'b1;
    tick();
    start = 1'b0;
    run_samples(N, 0, ones, gl);
    clr = 1'b1;
    ack = 1'b1;
    start = 1'b1;
    tick();
    clr = 1'b0;
    ack = 1'b0;
    start = 1'b0;
    checks++;
    if (busy !== 1'b0 || valid !== 1'b0 || result !== model(0)) begin
      errors++;
      $display("FAIL clr_done: busy=%0b valid=%0b result=%0d, want 0 0 %0d", busy, valid, result, model(0));
    end
    $display("clr: result retained=%0d", result);
  endtask

  initial begin
    test_reset();
    test_window(1, "all_ones");
    test_window(0, "all_zeros");
    test_window(2, "alternating");
    for (int r = 0; r < 3; r++) test_window(3, "random");
    test_ignored();
    test_back_to_back();
    test_reset_midrun();
    test_clr();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
